// File: rtl/req_arb_pkg.sv
// rtl/req_arb_pkg.sv - shared types and defaults for the round-robin request arbiter
//
// Purpose: FSM state encoding and the default requester count used by
//          req_arbiter4 and its picker.
// Ports:   none (package).
package req_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int ARB_N_DEFAULT = 4;

endpackage : req_arb_pkg

// File: rtl/req_arbiter4_rr_pick.sv
// rtl/req_arbiter4_rr_pick.sv - combinational rotate-priority picker
//
// Purpose: finds the first set bit of pend, scanning upward from ptr and
//          wrapping from N-1 back to 0.
// Ports:
//   pend  in  N     pending-request vector
//   ptr   in  IDXW  scan start position
//   pick  out IDXW  index of the chosen request (0 when any=0)
//   any   out 1     at least one pend bit is set
module rr_pick #(
  parameter  int N    = 4,
  localparam int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    pend,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] pick,
  output logic            any
);

  logic [IDXW-1:0] scan_idx;
  logic            found;

  assign any = |pend;

  // N is a power of two, so the IDXW-bit add wraps N-1 -> 0 for free.
  always_comb begin
    pick     = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = ptr + IDXW'(i);
      if (!found && pend[scan_idx]) begin
        pick  = scan_idx;
        found = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/req_arbiter4.sv
// rtl/req_arbiter4.sv - round-robin request arbiter feeding encoder4to2
//
// Purpose: latches request pulses and issues one registered one-hot grant at a
//          time under a valid/ready handshake. An IDLE bubble follows every
//          accepted grant. Optional macro ARB_IDX_EN adds a registered binary
//          grant index port.
// Ports:
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   req        in   N     request pulses/levels, latched into pend
//   gnt        out  N     registered one-hot grant, 0 when gnt_valid=0
//   gnt_valid  out  1     grant presented to the consumer
//   gnt_ready  in   1     consumer accepts the grant on this edge
//   pend       out  N     pending-request register
//   gnt_idx    out  IDXW  binary index of gnt (ARB_IDX_EN only)
module req_arbiter4
  import req_arb_pkg::*;
#(
  parameter  int N    = ARB_N_DEFAULT,
  localparam int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  input  logic            gnt_ready,
  output logic [N-1:0]    pend
`ifdef ARB_IDX_EN
  ,
  output logic [IDXW-1:0] gnt_idx
`endif
);

  arb_state_t      state_q, state_d;
  logic [N-1:0]    pend_q, pend_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    served;
  logic [IDXW-1:0] pick;
  logic            any;
  logic [IDXW-1:0] gnt_pos;
  logic            accept;

  // Picker sees only registered pend: no combinational path req -> gnt.
  rr_pick #(.N(N)) u_pick (
    .pend (pend_q),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  assign accept = (state_q == ARB_GRANT) && gnt_ready;
  assign served = accept ? gnt_q : '0;

  // A req bit arriving on its own accept edge survives the clear.
  assign pend_d = (pend_q & ~served) | req;

  // Binary position of the current one-hot grant, used to advance ptr.
  always_comb begin
    gnt_pos = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) begin
        gnt_pos = gnt_pos | IDXW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        gnt_d = '0;
        if (any) begin
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (gnt_ready) begin
          gnt_d   = '0;
          ptr_d   = gnt_pos + IDXW'(1);
          state_d = ARB_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      pend_q  <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = (state_q == ARB_GRANT);
  assign pend      = pend_q;

`ifdef ARB_IDX_EN
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;

  // Tracks gnt exactly: loaded with the pick, cleared on accept.
  always_comb begin
    gnt_idx_d = gnt_idx_q;
    if (state_q == ARB_IDLE) begin
      gnt_idx_d = any ? pick : '0;
    end else if (gnt_ready) begin
      gnt_idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_idx_q <= '0;
    end else begin
      gnt_idx_q <= gnt_idx_d;
    end
  end

  assign gnt_idx = gnt_idx_q;
`endif

endmodule : req_arbiter4

// File: tb/tb_req_arbiter4.sv
// tb/tb_req_arbiter4.sv - self-checking bench for req_arbiter4
module tb_req_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       gnt_ready;
  logic [3:0] pend;
`ifdef ARB_IDX_EN
  logic [1:0] gnt_idx;
`endif

  int tests;
  int fails;
  bit mon_en;
  logic [3:0] sb[$];

  req_arbiter4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready),
    .pend      (pend)
`ifdef ARB_IDX_EN
    ,
    .gnt_idx   (gnt_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  // Scoreboard: each accepted grant must match the next expected one.
  always @(negedge clk) begin
    if (mon_en && rst_n && gnt_valid && gnt_ready) begin
      logic [3:0] e;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $error("FAIL sb_unexpected: observed %b expected none", gnt);
      end else begin
        e = sb.pop_front();
        assert (gnt === e) else begin
          fails++;
          $error("FAIL sb_grant: observed %b expected %b", gnt, e);
        end
`ifdef ARB_IDX_EN
        tests++;
        assert (gnt_idx === ((e == 4'b0010) ? 2'd1 : (e == 4'b0100) ? 2'd2 :
                             (e == 4'b1000) ? 2'd3 : 2'd0)) else begin
          fails++;
          $error("FAIL sb_idx: observed %0d for grant %b", gnt_idx, e);
        end
`endif
      end
    end
  end

  // Encoder input contract: one-hot or zero, and zero whenever not valid.
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      assert ($onehot0(gnt) && (gnt_valid || gnt == 4'b0000)) else begin
        fails++;
        $error("FAIL onehot: observed gnt=%b valid=%b expected onehot0", gnt, gnt_valid);
      end
    end
  end

  logic [3:0] t3_tbl [8];

  initial begin
    tests     = 0;
    fails     = 0;
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    req       = 4'b1111;
    gnt_ready = 1'b0;
    t3_tbl    = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                  4'b0100, 4'b0000, 4'b1000, 4'b0000};
    #2;
    mon_en = 1'b1;

    // 1: reset holds everything at zero even with all requests high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_valid", gnt_valid, 1'b0);
      chk("rst_pend", pend, 4'b0000);
    end
    rst_n = 1'b1;
    req   = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_gnt", gnt, 4'b0000);
      chk("idle_valid", gnt_valid, 1'b0);
    end

    // 2: single request latency
    gnt_ready = 1'b1;
    req = 4'b0100;
    sb.push_back(4'b0100);
    step();
    req = 4'b0000;
    chk("t2_pend", pend, 4'b0100);
    chk("t2_valid0", gnt_valid, 1'b0);
    step();
    chk("t2_gnt", gnt, 4'b0100);
    chk("t2_valid1", gnt_valid, 1'b1);
`ifdef ARB_IDX_EN
    chk("t2_idx", gnt_idx, 2'd2);
`endif
    step();
    chk("t2_gnt_clr", gnt, 4'b0000);
    chk("t2_pend_clr", pend, 4'b0000);
    chk("t2_sb", sb.size(), 0);

    // 3: all four requesters, round-robin with idle bubbles
    do_reset();
    gnt_ready = 1'b1;
    req = 4'b1111;
    sb.push_back(4'b0001); sb.push_back(4'b0010);
    sb.push_back(4'b0100); sb.push_back(4'b1000);
    step();
    req = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t3_gnt%0d", i), gnt, t3_tbl[i]);
      chk($sformatf("t3_valid%0d", i), gnt_valid, t3_tbl[i] != 4'b0000);
    end
    // ptr wrapped to 0: bit 0 wins over bit 1
    req = 4'b0011;
    sb.push_back(4'b0001); sb.push_back(4'b0010);
    step();
    req = 4'b0000;
    drain("t3_wrap", 10);

    // 4: grant held under back-pressure while new requests land
    do_reset();
    gnt_ready = 1'b0;
    req = 4'b0010;
    sb.push_back(4'b0010); sb.push_back(4'b1000); sb.push_back(4'b0001);
    step();
    req = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_gnt", gnt, 4'b0010);
      chk("t4_hold_valid", gnt_valid, 1'b1);
    end
    chk("t4_pend", pend, 4'b1011);
    req = 4'b0000;
    gnt_ready = 1'b1;
    drain("t4_drain", 12);

    // 5: re-request on the accept edge is kept and served later
    do_reset();
    gnt_ready = 1'b1;
    req = 4'b1101;
    sb.push_back(4'b0001); sb.push_back(4'b0100);
    sb.push_back(4'b1000); sb.push_back(4'b0100);
    step();
    req = 4'b0000;
    step();
    step();
    step();
    chk("t5_gnt4", gnt, 4'b0100);
    req = 4'b0100;
    step();
    req = 4'b0000;
    chk("t5_pend", pend, 4'b1100);
    drain("t5_drain", 12);

    // 6: asynchronous reset mid-grant
    do_reset();
    gnt_ready = 1'b0;
    req = 4'b0110;
    step();
    req = 4'b0000;
    step();
    chk("t6_pre_valid", gnt_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_gnt", gnt, 4'b0000);
    chk("t6_valid", gnt_valid, 1'b0);
    chk("t6_pend", pend, 4'b0000);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t6_post_valid", gnt_valid, 1'b0);
      chk("t6_post_pend", pend, 4'b0000);
    end

    chk("sb_final", sb.size(), 0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_req_arbiter4
